// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting directly in front of decode. It owns the
// fetch PC, issues in-order word reads to instruction memory, buffers the
// returned words together with their PCs in a small FIFO and presents the
// FIFO head to decode as {pc, insn}. Decode treats insn == 0 as a NOP.
// A branch/jump redirect flushes the buffer. It also arranges for responses
// that are still in flight to be thrown away when they come back.
//
// Parameters
//   RESET_PC    fetch PC loaded on reset
//   FIFO_DEPTH  instruction buffer entries (power of 2, >= 2)
//   MAX_OUTSTD  max IMEM requests in flight (1..FIFO_DEPTH)
//
// Ports
//   clock        in   1   rising-edge clock
//   reset        in   1   asynchronous, active-high reset
//   imem_req     out  1   read request, accepted every cycle it is high
//   imem_addr    out  32  word-aligned read address (the fetch PC)
//   imem_rvalid  in   1   in-order read response valid
//   imem_rdata   in   32  read response instruction word
//   stall        in   1   decode cannot accept; hold the current output
//   redirect     in   1   branch/jump taken; flush and refetch
//   redirect_pc  in   32  new fetch target, bits [1:0] ignored
//   pc           out  32  PC of the presented instruction (0 when not valid)
//   insn         out  32  presented instruction (0 when not valid)
//   insn_valid   out  1   FIFO head is valid
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   perf_fetched out  32  number of instructions handed to decode
//   perf_stall   out  32  cycles with a valid instruction held by stall
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8002_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTSTD = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] insn,
  output logic        insn_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);

  localparam int FA_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FC_W = FA_W + 1;
  localparam int PQ_W = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
  localparam int OC_W = $clog2(MAX_OUTSTD + 1);

  // Fetch PC and request bookkeeping
  logic [31:0]     fetch_pc;
  logic [OC_W-1:0] outstanding;
  logic [OC_W-1:0] drop_cnt;

  // PC queue: address of every request in flight, oldest at pcq_rd
  logic [31:0]     pcq [MAX_OUTSTD];
  logic [PQ_W-1:0] pcq_rd;
  logic [PQ_W-1:0] pcq_wr;

  // Instruction buffer
  logic [31:0]     fifo_pc   [FIFO_DEPTH];
  logic [31:0]     fifo_insn [FIFO_DEPTH];
  logic [FA_W-1:0] rd_ptr;
  logic [FA_W-1:0] wr_ptr;
  logic [FC_W-1:0] fifo_count;

  logic [31:0] credits_used;
  logic        issue;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;
  logic        redirect_pc_low_unused;

  // The PC queue depth need not be a power of two, so wrap explicitly.
  function automatic logic [PQ_W-1:0] pcq_next(input logic [PQ_W-1:0] p);
    return (p == PQ_W'(MAX_OUTSTD - 1)) ? '0 : p + PQ_W'(1);
  endfunction

  assign redirect_target        = {redirect_pc[31:2], 2'b00};
  assign redirect_pc_low_unused = ^redirect_pc[1:0];

  // Credits count both buffered words and reads still in flight (including
  // ones that will be dropped), so a returning word always has a free slot.
  // The pre-pop occupancy is used deliberately to keep the request path
  // independent of stall.
  always_comb begin
    credits_used = 32'(fifo_count) + 32'(outstanding);
  end

  assign issue = ~reset & ~redirect
               & (credits_used < 32'(FIFO_DEPTH))
               & (32'(outstanding) < 32'(MAX_OUTSTD));

  assign push = imem_rvalid & ~redirect & (drop_cnt == '0);
  assign pop  = insn_valid & ~stall & ~redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  // Outputs come straight from the registered FIFO head; nothing here
  // depends combinationally on imem_rdata.
  assign insn_valid = (fifo_count != '0);
  assign pc         = insn_valid ? fifo_pc[rd_ptr]   : 32'h0;
  assign insn       = insn_valid ? fifo_insn[rd_ptr] : 32'h0;

  // Fetch PC: redirect wins, otherwise advance by one word per issued read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
    end else if (issue) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Outstanding reads: every issue adds one, every response retires one,
  // whether that response is kept or dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding + OC_W'(issue) - OC_W'(imem_rvalid);
    end
  end

  // Drop counter: on redirect every read still in flight becomes stale.
  // A response arriving in the redirect cycle itself is already being
  // discarded, so it is not counted again.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= outstanding - OC_W'(imem_rvalid);
    end else if (imem_rvalid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - OC_W'(1);
    end
  end

  // PC queue pointers. Entries are not flushed on redirect; the stale
  // responses still return in order and retire their own entries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcq_rd <= '0;
      pcq_wr <= '0;
    end else begin
      if (issue) begin
        pcq_wr <= pcq_next(pcq_wr);
      end
      if (imem_rvalid) begin
        pcq_rd <= pcq_next(pcq_rd);
      end
    end
  end

  // PC queue storage carries data only, so it needs no reset.
  always_ff @(posedge clock) begin
    if (issue) begin
      pcq[pcq_wr] <= fetch_pc;
    end
  end

  // Instruction buffer control. Simultaneous push and pop is fine even when
  // full; credits keep a lone push away from a full buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FA_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FA_W'(1);
      end
      fifo_count <= fifo_count + FC_W'(push) - FC_W'(pop);
    end
  end

  // Instruction buffer storage: each word is paired with the PC of the
  // oldest in-flight request, which is the one it answers.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= pcq[pcq_rd];
      fifo_insn[wr_ptr] <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Performance counters: instructions delivered, and cycles decode held a
  // valid instruction. Both wrap naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (insn_valid && stall) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`else
  // Built without performance counters.
`endif

endmodule
